conv_window_engine: RTL and testbench

- Streaming 2-D convolution engine for the video filter pipeline: one signed pixel per clock in raster order.
- Maintains an N×N window over the last N lines, with line storage of WIDTH pixels per line.
- Each cycle, multiplies the window element-wise by a runtime N×N kernel and emits the registered sum.
- Sits between the grayscale stage and the VGA output mux; edge/identity filters are instances with different kernels.

---
 rtl/conv_window_engine.sv | 72 +++++++
 tb/tb_conv_window_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_engine.sv
// Streaming N x N convolution: raster pixels in, sliding window and
// registered kernel-weighted sum out, one pixel per clock.
module conv_window_engine #(
  parameter int N     = 3,
  parameter int WIDTH = 640,
  parameter int BITS  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [BITS-1:0]           pixel_in,
  input  logic [N-1:0][N-1:0][BITS-1:0]    kernel_in,
  output logic [N-1:0][N-1:0][BITS-1:0]    window,
  output logic signed [BITS-1:0]           ans
);

  localparam int DEPTH = (N - 1) * WIDTH + N;
  localparam int PW    = 2 * BITS;
  localparam int ACC_W = PW + $clog2(N * N);

  // hist[0] is the newest sample; hist[d] is the pixel d captures back.
  logic [BITS-1:0] hist [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
    end else begin
      hist[0] <= pixel_in;
      for (int i = 1; i < DEPTH; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign window[r][c] = hist[(N-1-r)*WIDTH + (N-1-c)];
    end
  end

  logic signed [ACC_W-1:0] sum;
  logic signed [PW-1:0]    opk;
  logic signed [PW-1:0]    opw;
  logic signed [PW-1:0]    prod;

  // Operands are sign-extended to full width so the low PW bits of
  // the product are exact; the accumulator carries log2(N*N) guard bits.
  always_comb begin
    sum  = '0;
    opk  = '0;
    opw  = '0;
    prod = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        opk  = {{BITS{kernel_in[r][c][BITS-1]}}, kernel_in[r][c]};
        opw  = {{BITS{window[r][c][BITS-1]}}, window[r][c]};
        prod = opk * opw;
        sum  = sum + {{(ACC_W-PW){prod[PW-1]}}, prod};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans <= '0;
    end else begin
      ans <= sum[BITS-1:0];
    end
  end

endmodule

// File: tb/tb_conv_window_engine.sv
// Directed checks of window mapping, latency, filters, wrap and
// per-edge kernel sampling for conv_window_engine (N=3, WIDTH=8).
module tb_conv_window_engine;

  localparam int N     = 3;
  localparam int WIDTH = 8;
  localparam int BITS  = 16;

  logic                          clk = 1'b0;
  logic                          reset;
  logic signed [BITS-1:0]        pixel_in;
  logic [N-1:0][N-1:0][BITS-1:0] kernel_in;
  logic [N-1:0][N-1:0][BITS-1:0] window;
  logic signed [BITS-1:0]        ans;

  int checks = 0;
  int passed = 0;
  int hq[$];

  conv_window_engine #(
    .N(N), .WIDTH(WIDTH), .BITS(BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pixel_in(pixel_in),
    .kernel_in(kernel_in),
    .window(window),
    .ans(ans)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pixel_in = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic k_clear();
    kernel_in = '0;
  endtask

  task automatic k_identity();
    kernel_in = '0;
    kernel_in[1][1] = 16'sd1;
  endtask

  task automatic k_horiz();
    kernel_in = '0;
    for (int r = 0; r < N; r++) begin
      kernel_in[r][0] = 16'sd1;
      kernel_in[r][2] = -16'sd1;
    end
  endtask

  task automatic k_vert();
    kernel_in = '0;
    for (int c = 0; c < N; c++) begin
      kernel_in[0][c] = 16'sd1;
      kernel_in[2][c] = -16'sd1;
    end
  endtask

  task automatic k_ones();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        kernel_in[r][c] = 16'sd1;
      end
    end
  endtask

  function automatic int mw(input int r, input int c);
    int d;
    d = (N-1-r)*WIDTH + (N-1-c);
    return (d < hq.size()) ? hq[d] : 0;
  endfunction

  task automatic test_reset();
    k_clear();
    kernel_in[2][2] = 16'sd3;
    for (int i = 0; i < 12; i++) begin
      pixel_in = 16'($urandom_range(1, 1000));
      tick();
    end
    reset = 1'b1;
    tick();
    checks++;
    if (window !== '0) $display("FAIL reset_window got=%h exp=0", window);
    else passed++;
    checks++;
    if (ans !== 16'sd0) $display("FAIL reset_ans got=%0d exp=0", ans);
    else passed++;
    reset = 1'b0;
    pixel_in = 16'sd7;
    tick();
    checks++;
    if (window[2][2] !== 16'd7 || window[2][1] !== 16'd0)
      $display("FAIL reset_first_pix got=%h exp=7 alone", window);
    else passed++;
    checks++;
    if (ans !== 16'sd0) $display("FAIL reset_ans_rel got=%0d exp=0", ans);
    else passed++;
    pixel_in = 16'sd5;
    tick();
    checks++;
    if (ans !== 16'sd21) $display("FAIL reset_ans_2nd got=%0d exp=21", ans);
    else passed++;
  endtask

  task automatic test_identity();
    int e;
    do_reset();
    k_identity();
    for (int k = 0; k < 25; k++) begin
      pixel_in = 16'(k);
      tick();
      e = (k >= 10) ? k - 10 : 0;
      checks++;
      if (ans !== 16'(e)) $display("FAIL identity k=%0d got=%0d exp=%0d", k, ans, e);
      else passed++;
      checks++;
      if (window[2][2] !== 16'(k))
        $display("FAIL newest k=%0d got=%0d exp=%0d", k, window[2][2], k);
      else passed++;
    end
  endtask

  task automatic test_horizontal();
    do_reset();
    k_horiz();
    for (int k = 0; k < 30; k++) begin
      pixel_in = 16'(k);
      tick();
      if (k >= 20) begin
        checks++;
        if (ans !== -16'sd6) $display("FAIL horiz k=%0d got=%0d exp=-6", k, ans);
        else passed++;
      end
    end
    for (int j = 0; j < 25; j++) begin
      pixel_in = 16'sd100;
      tick();
      if (j >= 21) begin
        checks++;
        if (ans !== 16'sd0) $display("FAIL horiz_const j=%0d got=%0d exp=0", j, ans);
        else passed++;
      end
    end
  endtask

  task automatic test_vertical();
    do_reset();
    k_vert();
    for (int k = 0; k < 30; k++) begin
      pixel_in = 16'(k);
      tick();
      if (k >= 20) begin
        checks++;
        if (ans !== -16'sd48) $display("FAIL vert k=%0d got=%0d exp=-48", k, ans);
        else passed++;
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    k_ones();
    for (int j = 0; j < 24; j++) begin
      pixel_in = 16'sd32767;
      tick();
      if (j >= 21) begin
        checks++;
        if (ans !== 16'sd32759) $display("FAIL ovf_max j=%0d got=%0d exp=32759", j, ans);
        else passed++;
      end
    end
    for (int j = 0; j < 24; j++) begin
      pixel_in = -16'sd1;
      tick();
      if (j >= 21) begin
        checks++;
        if (ans !== -16'sd9) $display("FAIL ovf_neg j=%0d got=%0d exp=-9", j, ans);
        else passed++;
      end
    end
  endtask

  task automatic test_kernel_switch();
    int s;
    int kv;
    logic signed [BITS-1:0] e;
    do_reset();
    hq.delete();
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 1) k_horiz();
      else k_identity();
      s = 0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (k % 2 == 1) kv = (c == 0) ? 1 : (c == 2) ? -1 : 0;
          else kv = (r == 1 && c == 1) ? 1 : 0;
          s += kv * mw(r, c);
        end
      end
      e = 16'(s);
      pixel_in = 16'(k * 3 + 1);
      hq.push_front(k * 3 + 1);
      tick();
      checks++;
      if (ans !== e) $display("FAIL kswitch k=%0d got=%0d exp=%0d", k, ans, e);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    pixel_in = '0;
    kernel_in = '0;
    tick();
    reset = 1'b0;
    test_reset();
    test_identity();
    test_horizontal();
    test_vertical();
    test_overflow();
    test_kernel_switch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
